// File: rtl/muldiv_pkg.sv
// Shared opcode/state encodings and constants for the iterative MIPS HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO: shift-add multiply, restoring divide,
// magnitude datapath with a final sign-fix cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W  = WIDTH;
    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

    muldiv_state_e   r_state;
    muldiv_op_e      r_op;
    logic [CW-1:0]   r_cnt;
    logic [2*W-1:0]  r_acc;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_a_raw;
    logic            r_neg_res;
    logic            r_neg_rem;
    logic            r_busy;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;

    // Operand conditioning at issue time.
    logic            w_is_signed;
    logic            w_is_muldiv;
    logic            w_is_div_in;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;

    assign w_is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_is_div_in = (op == OP_DIV)  || (op == OP_DIVU);
    assign w_is_muldiv = w_is_div_in || (op == OP_MULT) || (op == OP_MULTU);
    assign w_a_neg     = w_is_signed && op_a[W-1];
    assign w_b_neg     = w_is_signed && op_b[W-1];
    assign w_a_mag     = w_a_neg ? -op_a : op_a;
    assign w_b_mag     = w_b_neg ? -op_b : op_b;

    // Multiply step: accumulator high half gains the multiplicand when the
    // current multiplier bit (acc LSB) is set, then the whole thing shifts right.
    logic [W:0]      w_mul_sum;
    logic [2*W-1:0]  w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Divide step: acc = {remainder, remaining dividend bits / quotient bits}.
    // The shifted partial remainder is W+1 bits wide, so the trial compare is too.
    logic            w_div_ge;
    logic [W-1:0]    w_div_diff;
    logic [W-1:0]    w_div_rem;
    logic [2*W-1:0]  w_div_next;

    assign w_div_ge   = r_acc[2*W-1:W-1] >= {1'b0, r_b};
    assign w_div_diff = r_acc[2*W-2:W-1] - r_b;
    assign w_div_rem  = w_div_ge ? w_div_diff : r_acc[2*W-2:W-1];
    assign w_div_next = {w_div_rem, r_acc[W-2:0], w_div_ge};

    // Sign correction applied in the FIX cycle.
    logic            w_is_div;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_quot;
    logic [W-1:0]    w_rem;

    assign w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign w_prod   = r_neg_res ? -r_acc : r_acc;
    assign w_quot   = r_neg_res ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem    = r_neg_rem ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_op      <= OP_MULT;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_a_raw   <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_busy    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && (op == OP_MTHI)) begin
                        r_hi <= op_a;
                    end else if (start && (op == OP_MTLO)) begin
                        r_lo <= op_a;
                    end else if (start && w_is_muldiv) begin
                        r_op      <= muldiv_op_e'(op);
                        r_cnt     <= '0;
                        r_a_raw   <= op_a;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                        if (w_is_div_in) begin
                            r_acc <= {{W{1'b0}}, w_a_mag};
                            r_b   <= w_b_mag;
                        end else begin
                            r_acc <= {{W{1'b0}}, w_b_mag};
                            r_b   <= w_a_mag;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (!w_is_div) begin
                        r_hi <= w_prod[2*W-1:W];
                        r_lo <= w_prod[W-1:0];
                    end else if (r_b == '0) begin
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
